// File: rtl/amiq_mux_arbiter.sv
// amiq_mux_arbiter
// Round-robin arbiter sharing a 2:1 mux between two single-bit requesters.
// Grants one owner at a time, drives the mux select, and registers the mux
// output one cycle later together with the index of the owner it came from.
// A burst limit (MAX_BURST) bounds how long one owner holds the mux while the
// other requester is waiting.
//
// Optional build macro: AMIQ_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 has fixed priority (requester 1 may starve)
//   undefined -> round-robin (default)

module amiq_mux_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req0,
   input  logic i_req1,
   output logic o_gnt0,
   output logic o_gnt1,
   output logic o_sel,
   input  logic i_mux_out,
   output logic o_dout,
   output logic o_dout_valid,
   output logic o_dout_src
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

`ifdef AMIQ_ARB_FIXED_PRIO_EN
   localparam logic FIXED_PRIO = 1'b1;
`else
   localparam logic FIXED_PRIO = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_burst_cnt;
   logic [CNT_W-1:0] w_burst_cnt_next;
   logic             r_last_owner;
   logic             w_last_owner_next;
   logic             w_burst_last;
   logic             r_gnt0;
   logic             r_gnt1;
   logic             r_sel;
   logic             r_dout;
   logic             r_dout_valid;
   logic             r_dout_src;

   assign w_burst_last = (r_burst_cnt == BURST_LAST);

   // Next-state selection: idle arbitration, release hand-over and burst expiry.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_req0 && i_req1) begin
               // Contention from idle: favour the requester that did not own last.
               if ((FIXED_PRIO == 1'b1) || (r_last_owner == 1'b1)) begin
                  w_next_state = ST_OWN0;
               end else begin
                  w_next_state = ST_OWN1;
               end
            end else if (i_req0) begin
               w_next_state = ST_OWN0;
            end else if (i_req1) begin
               w_next_state = ST_OWN1;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_OWN0: begin
            if (!i_req0) begin
               w_next_state = i_req1 ? ST_OWN1 : ST_IDLE;
            end else if (i_req1 && w_burst_last && (FIXED_PRIO == 1'b0)) begin
               w_next_state = ST_OWN1;
            end else begin
               w_next_state = ST_OWN0;
            end
         end
         ST_OWN1: begin
            if (!i_req1) begin
               w_next_state = i_req0 ? ST_OWN0 : ST_IDLE;
            end else if (i_req0 && w_burst_last) begin
               w_next_state = ST_OWN0;
            end else begin
               w_next_state = ST_OWN1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Burst counter and last-owner bookkeeping: restart on every ownership change.
   always_comb begin
      w_burst_cnt_next  = r_burst_cnt;
      w_last_owner_next = r_last_owner;
      if (w_next_state != r_state) begin
         w_burst_cnt_next = {CNT_W{1'b0}};
         if (w_next_state == ST_OWN0) begin
            w_last_owner_next = 1'b0;
         end else if (w_next_state == ST_OWN1) begin
            w_last_owner_next = 1'b1;
         end else begin
            w_last_owner_next = r_last_owner;
         end
      end else if ((r_state != ST_IDLE) && !w_burst_last) begin
         w_burst_cnt_next = r_burst_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         w_burst_cnt_next = r_burst_cnt;
      end
   end

   // Control registers; grant/select flops are loaded from the next state so
   // they always mirror the state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_burst_cnt  <= {CNT_W{1'b0}};
         r_last_owner <= 1'b1;
         r_gnt0       <= 1'b0;
         r_gnt1       <= 1'b0;
         r_sel        <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_burst_cnt  <= w_burst_cnt_next;
         r_last_owner <= w_last_owner_next;
         r_gnt0       <= (w_next_state == ST_OWN0);
         r_gnt1       <= (w_next_state == ST_OWN1);
         r_sel        <= (w_next_state == ST_OWN1);
      end
   end

   // Datapath: sample the mux every edge, tag it with the select that produced it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_dout       <= 1'b0;
         r_dout_valid <= 1'b0;
         r_dout_src   <= 1'b0;
      end else begin
         r_dout       <= i_mux_out;
         r_dout_valid <= r_gnt0 | r_gnt1;
         r_dout_src   <= r_sel;
      end
   end

   assign o_gnt0       = r_gnt0;
   assign o_gnt1       = r_gnt1;
   assign o_sel        = r_sel;
   assign o_dout       = r_dout;
   assign o_dout_valid = r_dout_valid;
   assign o_dout_src   = r_dout_src;

endmodule

// File: tb/tb_amiq_mux_arbiter.sv
// Directed testbench for amiq_mux_arbiter.
// Observed vector per DUT: {gnt0, gnt1, sel, dout_valid, dout, dout_src}.
// dut_a: MAX_BURST=4, mux in0/in1 driven by the bench.
// dut_b: MAX_BURST=1, mux in0=0, in1=1 (so dout echoes the previous select).

module tb_amiq_mux_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req0_a = 1'b0, req1_a = 1'b0;
   logic req0_b = 1'b0, req1_b = 1'b0;
   logic in0_a = 1'b0, in1_a = 1'b1;
   logic gnt0_a, gnt1_a, sel_a, dout_a, dv_a, dsrc_a;
   logic gnt0_b, gnt1_b, sel_b, dout_b, dv_b, dsrc_b;
   logic mux_a, mux_b;
   logic [5:0] obs_a, obs_b;
   logic [5:0] exp_cont [12];
   logic [5:0] exp_b1 [6];
   int n_pass = 0;
   int n_total = 0;

   assign mux_a = sel_a ? in1_a : in0_a;
   assign mux_b = sel_b ? 1'b1 : 1'b0;
   assign obs_a = {gnt0_a, gnt1_a, sel_a, dv_a, dout_a, dsrc_a};
   assign obs_b = {gnt0_b, gnt1_b, sel_b, dv_b, dout_b, dsrc_b};

   always #5 clk = ~clk;

   amiq_mux_arbiter #(.MAX_BURST(4)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_req0(req0_a), .i_req1(req1_a),
      .o_gnt0(gnt0_a), .o_gnt1(gnt1_a), .o_sel(sel_a), .i_mux_out(mux_a),
      .o_dout(dout_a), .o_dout_valid(dv_a), .o_dout_src(dsrc_a)
   );

   amiq_mux_arbiter #(.MAX_BURST(1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_req0(req0_b), .i_req1(req1_b),
      .o_gnt0(gnt0_b), .o_gnt1(gnt1_b), .o_sel(sel_b), .i_mux_out(mux_b),
      .o_dout(dout_b), .o_dout_valid(dv_b), .o_dout_src(dsrc_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      // Round-robin contention, MAX_BURST=4, in0=0/in1=1 so dout = previous sel.
      exp_cont = '{6'b100000, 6'b100100, 6'b100100, 6'b100100,
                   6'b011100, 6'b011111, 6'b011111, 6'b011111,
                   6'b100111, 6'b100100, 6'b100100, 6'b100100};
      // MAX_BURST=1 under contention: alternate every cycle starting with 0.
      exp_b1 = '{6'b100000, 6'b011100, 6'b100111, 6'b011100, 6'b100111, 6'b011100};

      // Reset state, asserted without any clock edge yet.
      #2;
      chk("reset_a", obs_a, 6'b000000);
      chk("reset_b", obs_b, 6'b000000);
      #10;
      rst = 1'b0;

      // Idle with no requests.
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("idle%0d", i), obs_a, 6'b000000);
      end

`ifdef AMIQ_ARB_FIXED_PRIO_EN
      // Fixed priority: requester 0 keeps the mux under constant contention.
      req0_a = 1'b1; req1_a = 1'b1; in0_a = 1'b0;
      req0_b = 1'b1; req1_b = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("fp_a%0d", k), obs_a, (k == 1) ? 6'b100000 : 6'b100100);
         chk($sformatf("fp_b%0d", k), obs_b, (k == 1) ? 6'b100000 : 6'b100100);
      end
`else
      // Contention round-robin on both instances.
      req0_a = 1'b1; req1_a = 1'b1; in0_a = 1'b0; in1_a = 1'b1;
      req0_b = 1'b1; req1_b = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("cont%0d", k), obs_a, exp_cont[k-1]);
         if (k <= 6) begin
            chk($sformatf("mb1_%0d", k), obs_b, exp_b1[k-1]);
         end
         if (k == 6) begin
            req0_b = 1'b0; req1_b = 1'b0;
         end
      end

      // Early release: OWN1 with req0 waiting, req1 drops after 2 grant cycles.
      tick(); chk("rel13", obs_a, 6'b011100);
      tick(); chk("rel14", obs_a, 6'b011111);
      req1_a = 1'b0;
      tick(); chk("rel15", obs_a, 6'b100111);
      req1_a = 1'b1;
      // Burst count restarted: three more OWN0 cycles before the switch.
      tick(); chk("rel16", obs_a, 6'b100100);
      tick(); chk("rel17", obs_a, 6'b100100);
      tick(); chk("rel18", obs_a, 6'b100100);
      tick(); chk("rel19", obs_a, 6'b011100);
      // Simultaneous drop while owned goes straight to idle.
      req0_a = 1'b0; req1_a = 1'b0;
      tick(); chk("drop20", obs_a, 6'b000111);
      tick(); chk("drop21", obs_a, 6'b000000);

      // Single requester with in0 pattern 1,0,1 on the grant cycles.
      req0_a = 1'b1; in0_a = 1'b0;
      tick(); chk("single_a", obs_a, 6'b100000);
      in0_a = 1'b1;
      tick(); chk("single_b", obs_a, 6'b100110);
      in0_a = 1'b0;
      tick(); chk("single_c", obs_a, 6'b100100);
      in0_a = 1'b1; req0_a = 1'b0;
      tick(); chk("single_d", obs_a, 6'b000110);
      in0_a = 1'b0;
      tick(); chk("single_e", obs_a, 6'b000000);

      // Async reset mid-burst while OWN0 (last owner 0 before reset).
      req0_a = 1'b1;
      tick(); chk("rst_own0", obs_a, 6'b100000);
      tick(); chk("rst_own0b", obs_a, 6'b100100);
      #3;
      rst = 1'b1; req1_a = 1'b1;
      #1;
      chk("rst_async", obs_a, 6'b000000);
      #2;
      rst = 1'b0;
      tick(); chk("rst_regrant", obs_a, 6'b100000);
      req0_a = 1'b0; req1_a = 1'b0;
      tick(); chk("rst_idle", obs_a, 6'b000100);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
